multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle RISC-V datapath.
- Sequences fetch, decode, execute, memory and writeback over multiple clocks.
- Drives the datapath mux selects, the write enables, and the 3-bit extend-function select of the immediate extender.
- Sits beside the datapath: it takes opcode, funct3 and ALU flags from the instruction register and the ALU.

---
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  // Datapath status into the controller
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  // Controller outputs to the datapath
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       illegal;

  modport master (
    input  op, funct3, zero, lt,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
    output alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal
  );

  modport slave (
    output op, funct3, zero, lt,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
    input  alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// selects, write enables and immediate-extend select.
// Optional feature macro: ILLEGAL_TRAP_EN -- unknown opcodes park the FSM in a
// TRAP state (illegal=1) until reset; without it they act as a 2-cycle NOP.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master ctrl
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_OLDPC  = 2'b01;
  localparam logic [1:0] A_REGA   = 2'b10;
  localparam logic [1:0] B_REGB   = 2'b00;
  localparam logic [1:0] B_IMM    = 2'b01;
  localparam logic [1:0] B_FOUR   = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JUMP     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t state_q, state_d;

  // Enables before reset gating; selects go straight to the bus.
  logic pc_write_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic branch_taken;

  // State register; reset returns to FETCH and abandons any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch condition from funct3 and the ALU flags.
  always_comb begin
    branch_taken = 1'b0;
    case (ctrl.funct3)
      3'b000:  branch_taken = ctrl.zero;
      3'b001:  branch_taken = ~ctrl.zero;
      3'b100:  branch_taken = ctrl.lt;
      3'b101:  branch_taken = ~ctrl.lt;
      default: branch_taken = 1'b0;
    endcase
  end

  // Immediate-extend select, decoded from op every cycle.
  always_comb begin
    ctrl.imm_src = 3'b000;
    case (ctrl.op)
      OP_LOAD, OP_ITYPE, OP_JALR: ctrl.imm_src = 3'b000;
      OP_STORE:                   ctrl.imm_src = 3'b001;
      OP_BRANCH:                  ctrl.imm_src = 3'b010;
      OP_JAL:                     ctrl.imm_src = 3'b011;
      OP_LUI:                     ctrl.imm_src = 3'b100;
      default:                    ctrl.imm_src = 3'b000;
    endcase
  end

  // Next-state logic and Moore output decode (pc_write in BRANCH is the one Mealy term).
  always_comb begin
    state_d         = S_FETCH;
    pc_write_raw    = 1'b0;
    mem_write_raw   = 1'b0;
    ir_write_raw    = 1'b0;
    reg_write_raw   = 1'b0;
    ctrl.adr_src    = 1'b0;
    ctrl.alu_src_a  = A_PC;
    ctrl.alu_src_b  = B_REGB;
    ctrl.alu_op     = OP_ADD;
    ctrl.result_src = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ir_write_raw    = 1'b1;
        ctrl.alu_src_a  = A_PC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.alu_op     = OP_ADD;
        ctrl.result_src = RES_ALU;
        pc_write_raw    = 1'b1;
        state_d         = S_DECODE;
      end
      S_DECODE: begin
        // Speculative old_pc + imm lands in ALU-out for branches and jal.
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_ADD;
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_LUI:            state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = A_REGA;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_ADD;
        state_d        = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.adr_src = 1'b1;
        state_d      = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MDR;
        reg_write_raw   = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.adr_src  = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = A_REGA;
        ctrl.alu_src_b = B_REGB;
        ctrl.alu_op    = OP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = A_REGA;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        reg_write_raw   = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        // Target from DECODE sits in ALU-out; ALU compares rs1/rs2 here.
        ctrl.alu_src_a  = A_REGA;
        ctrl.alu_src_b  = B_REGB;
        ctrl.alu_op     = OP_SUB;
        ctrl.result_src = RES_ALUOUT;
        pc_write_raw    = branch_taken;
        state_d         = S_FETCH;
      end
      S_JALR_ADR: begin
        // rs1 + imm overwrites the speculative target in ALU-out.
        ctrl.alu_src_a = A_REGA;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_ADD;
        state_d        = S_JUMP;
      end
      S_JUMP: begin
        // Load target into PC while the ALU forms the link value old_pc + 4.
        ctrl.result_src = RES_ALUOUT;
        pc_write_raw    = 1'b1;
        ctrl.alu_src_a  = A_OLDPC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.alu_op     = OP_ADD;
        state_d         = S_ALUWB;
      end
      S_LUI: begin
        ctrl.result_src = RES_IMM;
        reg_write_raw   = 1'b1;
        state_d         = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Enables are held low for as long as reset is asserted.
  assign ctrl.pc_write  = pc_write_raw  & ~rst;
  assign ctrl.mem_write = mem_write_raw & ~rst;
  assign ctrl.ir_write  = ir_write_raw  & ~rst;
  assign ctrl.reg_write = reg_write_raw & ~rst;

`ifdef ILLEGAL_TRAP_EN
  assign ctrl.illegal = (state_q == S_TRAP);
`else
  assign ctrl.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction pushes its
// expected per-cycle control vector, and the DUT outputs are popped and
// compared one cycle at a time.
module tb_multicycle_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  multicycle_controller_if bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXEC_R,
    T_EXEC_I, T_ALUWB, T_BRANCH, T_JALR_ADR, T_JUMP, T_LUI, T_TRAP
  } tstate_t;

  typedef struct {
    string       tag;
    logic [16:0] vec;
  } exp_t;

  exp_t exp_q[$];

  // {pc_write, adr_src, mem_write, ir_write, reg_write, a, b, alu_op, result_src, imm_src, illegal}
  logic [16:0] obs;
  assign obs = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src, bus.imm_src,
                bus.illegal};

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end else begin
      $display("ok   %s vec=%05h", tag, got);
    end
  endtask

  function automatic tstate_t tb_next(tstate_t s, logic [6:0] o);
    case (s)
      T_FETCH:  return T_DECODE;
      T_DECODE: begin
        case (o)
          7'b0000011, 7'b0100011: return T_MEMADR;
          7'b0110011: return T_EXEC_R;
          7'b0010011: return T_EXEC_I;
          7'b1100011: return T_BRANCH;
          7'b1101111: return T_JUMP;
          7'b1100111: return T_JALR_ADR;
          7'b0110111: return T_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:    return T_TRAP;
`else
          default:    return T_FETCH;
`endif
        endcase
      end
      T_MEMADR:   return (o == 7'b0000011) ? T_MEMREAD : T_MEMWRITE;
      T_MEMREAD:  return T_MEMWB;
      T_EXEC_R:   return T_ALUWB;
      T_EXEC_I:   return T_ALUWB;
      T_JALR_ADR: return T_JUMP;
      T_JUMP:     return T_ALUWB;
      T_TRAP:     return T_TRAP;
      default:    return T_FETCH;
    endcase
  endfunction

  function automatic logic [16:0] exp_vec(tstate_t s, logic [6:0] o, logic [2:0] f3,
                                          logic z, logic l, logic r);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] a, b, aop, res;
    logic [2:0] imm;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    a = 0; b = 0; aop = 0; res = 0; imm = 0;
    case (o)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111: imm = 3'b100;
      default:    imm = 3'b000;
    endcase
    case (s)
      T_FETCH:    begin irw = 1; b = 2'b10; res = 2'b10; pcw = 1; end
      T_DECODE:   begin a = 2'b01; b = 2'b01; end
      T_MEMADR:   begin a = 2'b10; b = 2'b01; end
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin res = 2'b01; rw = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; end
      T_EXEC_R:   begin a = 2'b10; aop = 2'b10; end
      T_EXEC_I:   begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      T_ALUWB:    rw = 1;
      T_BRANCH: begin
        a = 2'b10; aop = 2'b01;
        pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) ||
              (f3 == 3'b100 && l) || (f3 == 3'b101 && !l);
      end
      T_JALR_ADR: begin a = 2'b10; b = 2'b01; end
      T_JUMP:     begin pcw = 1; a = 2'b01; b = 2'b10; end
      T_LUI:      begin res = 2'b11; rw = 1; end
      T_TRAP:     ill = 1;
      default:    ;
    endcase
    if (r) begin
      pcw = 0; mw = 0; irw = 0; rw = 0;
    end
    return {pcw, adr, mw, irw, rw, a, b, aop, res, imm, ill};
  endfunction

  // Compare one queued expectation against the DUT, mid-cycle.
  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty got=none exp=entry");
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.vec);
    end
  endtask

  // Entered at posedge+1 with the FSM in FETCH; leaves at posedge+1 of the next FETCH.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic z, input logic l);
    tstate_t s;
    int      n;
    bus.op = o; bus.funct3 = f3; bus.zero = z; bus.lt = l;
    s = T_FETCH;
    n = 0;
    do begin
      exp_q.push_back('{$sformatf("%s_c%0d", name, n + 1), exp_vec(s, o, f3, z, l, 1'b0)});
      s = tb_next(s, o);
      n++;
    end while (s != T_FETCH && n < 8);
    repeat (n) begin
      #1;
      pop_check();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.op = 7'b0000000; bus.funct3 = 3'b000; bus.zero = 1'b0; bus.lt = 1'b0;

    // Reset held for two cycles: enables low, FETCH selects visible.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back('{$sformatf("reset_c%0d", i + 1),
                        exp_vec(T_FETCH, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1)});
      pop_check();
    end
    rst = 1'b0;

    run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0);
    run_instr("add",     7'b0110011, 3'b000, 1'b0, 1'b0);
    run_instr("addi",    7'b0010011, 3'b000, 1'b0, 1'b0);
    run_instr("beq_t",   7'b1100011, 3'b000, 1'b1, 1'b0);
    run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0);
    run_instr("bne_nt",  7'b1100011, 3'b001, 1'b1, 1'b0);
    run_instr("blt_t",   7'b1100011, 3'b100, 1'b0, 1'b1);
    run_instr("bge_nt",  7'b1100011, 3'b101, 1'b0, 1'b1);
    run_instr("bf3_010", 7'b1100011, 3'b010, 1'b1, 1'b1);
    run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0);
    run_instr("jalr",    7'b1100111, 3'b000, 1'b0, 1'b0);
    run_instr("lui",     7'b0110111, 3'b000, 1'b0, 1'b0);

`ifndef ILLEGAL_TRAP_EN
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);
`endif

    // Reset during MEMADR of a store: back to FETCH, no store pulse.
    bus.op = 7'b0100011; bus.funct3 = 3'b010;
    exp_q.push_back('{"rmid_fetch",  exp_vec(T_FETCH,  7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0)});
    exp_q.push_back('{"rmid_decode", exp_vec(T_DECODE, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0)});
    repeat (2) begin
      #1;
      pop_check();
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    exp_q.push_back('{"rmid_memadr", exp_vec(T_MEMADR, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1)});
    #1;
    pop_check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr("after_rst_lw", 7'b0000011, 3'b010, 1'b0, 1'b0);

`ifdef ILLEGAL_TRAP_EN
    // Unknown op parks in TRAP until reset.
    bus.op = 7'b1111111; bus.funct3 = 3'b000;
    exp_q.push_back('{"trap_fetch",  exp_vec(T_FETCH,  7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0)});
    exp_q.push_back('{"trap_decode", exp_vec(T_DECODE, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0)});
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{$sformatf("trap_hold%0d", i), exp_vec(T_TRAP, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0)});
    repeat (5) begin
      #1;
      pop_check();
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr("post_trap_addi", 7'b0010011, 3'b000, 1'b0, 1'b0);
`endif

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
